// File: rtl/uop_pkg.sv
// Shared definitions for the micro-op controller: opcodes, FSM states,
// default sizes and FLAGS bit positions.
package uop_pkg;

    localparam int W_DEF    = 16;
    localparam int NREG_DEF = 8;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_MOV   = 4'h1,
        OP_ADD   = 4'h2,
        OP_SUB   = 4'h3,
        OP_AND   = 4'h4,
        OP_OR    = 4'h5,
        OP_XOR   = 4'h6,
        OP_LDI   = 4'h7,
        OP_SHL   = 4'h8,
        OP_SHR   = 4'h9,
        OP_SWAP  = 4'hA,
        OP_CMP   = 4'hB,
        OP_ILL_C = 4'hC,
        OP_ILL_D = 4'hD,
        OP_ILL_E = 4'hE,
        OP_ILL_F = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WB,
        S_WB2
    } state_e;

    function automatic logic op_writes(op_e op);
        return op inside {OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                          OP_LDI, OP_SHL, OP_SHR, OP_SWAP};
    endfunction

    function automatic logic op_sets_flags(op_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                          OP_SHL, OP_SHR, OP_CMP};
    endfunction

    function automatic logic op_illegal(op_e op);
        return op inside {OP_ILL_C, OP_ILL_D, OP_ILL_E, OP_ILL_F};
    endfunction

endpackage

// File: rtl/uop_alu.sv
// Combinational ALU: result truncated to W bits plus {C,N,Z} for that result.
module uop_alu
    import uop_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  op_e          op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] res_o,
    output logic [2:0]   flags_o
);

    logic [W:0] sum;
    logic [W:0] diff;
    logic       carry;

    // Top bit of the widened difference is the unsigned borrow (A < B).
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        res_o = a_i;
        carry = 1'b0;
        unique case (op_i)
            OP_ADD:         begin res_o = sum[W-1:0];  carry = sum[W];  end
            OP_SUB, OP_CMP: begin res_o = diff[W-1:0]; carry = diff[W]; end
            OP_AND:         res_o = a_i & b_i;
            OP_OR:          res_o = a_i | b_i;
            OP_XOR:         res_o = a_i ^ b_i;
            OP_SHL:         begin res_o = {a_i[W-2:0], 1'b0}; carry = a_i[W-1]; end
            OP_SHR:         begin res_o = {1'b0, a_i[W-1:1]}; carry = a_i[0];   end
            default:        res_o = a_i;
        endcase
        flags_o         = '0;
        flags_o[FLAG_C] = carry;
        flags_o[FLAG_N] = res_o[W-1];
        flags_o[FLAG_Z] = (res_o == '0);
    end

endmodule

// File: rtl/uop_ctrl.sv
// Micro-op controller: IDLE -> RD (operand fetch) -> WB (write-back) -> WB2 (SWAP
// second write), driving register-file selects and holding operands and FLAGS.
module uop_ctrl
    import uop_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [W-1:0]            INSTR,
    input  logic                    IVALID,
    output logic                    IREADY,
    output logic [$clog2(NREG)-1:0] ASEL,
    output logic [$clog2(NREG)-1:0] BSEL,
    output logic [$clog2(NREG)-1:0] DSEL,
    output logic [W-1:0]            DIN,
    output logic [W-1:0]            RIN,
    input  logic [W-1:0]            ABUS,
    input  logic [W-1:0]            BBUS,
    output logic                    DONE,
    output logic                    ERR,
    output logic [2:0]              FLAGS
);

    localparam int SW = $clog2(NREG);

    state_e         state_q, state_d;
    logic [W-1:0]   instr_q;
    logic [W-1:0]   a_q, b_q;
    logic [2:0]     flags_q;
    logic           run_q;
    logic           accept;

    op_e            op;
    logic [SW-1:0]  rd, ra, rb;
    logic [W-1:0]   alu_res;
    logic [2:0]     alu_flags;

    assign op = op_e'(instr_q[15:12]);
    assign rd = SW'(instr_q[11:9]);
    assign ra = SW'(instr_q[8:6]);
    assign rb = SW'(instr_q[5:3]);

    // run_q keeps IREADY low while reset is held and releases it on the first edge after.
    assign IREADY = run_q && (state_q == S_IDLE);
    assign accept = IREADY && IVALID;
    assign FLAGS  = flags_q;

    uop_alu #(.W(W)) u_alu (
        .op_i    (op),
        .a_i     (a_q),
        .b_i     (b_q),
        .res_o   (alu_res),
        .flags_o (alu_flags)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (accept) begin
                instr_q <= INSTR;
            end
            if (state_q == S_RD) begin
                a_q <= ABUS;
                b_q <= BBUS;
            end
            if (state_q == S_WB && op_sets_flags(op)) begin
                flags_q <= alu_flags;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ASEL    = '0;
        BSEL    = '0;
        DSEL    = '0;
        DIN     = '0;
        RIN     = '0;
        DONE    = 1'b0;
        ERR     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_RD;
            end
            S_RD: begin
                ASEL    = (op == OP_LDI)  ? '0 : ra;
                BSEL    = (op == OP_SWAP) ? rd : rb;
                if (op == OP_LDI) DIN = W'(instr_q[8:0]);
                state_d = S_WB;
            end
            S_WB: begin
                RIN = alu_res;
                if (op_writes(op)) DSEL = rd;
                if (op == OP_SWAP) begin
                    state_d = S_WB2;
                end else begin
                    DONE    = 1'b1;
                    ERR     = op_illegal(op);
                    state_d = S_IDLE;
                end
            end
            S_WB2: begin
                DSEL    = ra;
                RIN     = b_q;
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
